// File: rtl/ecc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ecc_pkg : shared widths, FSM states and helpers for ECC write-back   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ecc_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 64;
  localparam int CHK_W_DEF  = 8;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENC   = 2'd1,
    WRITE = 2'd2
  } wb_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ecc_wb_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ecc_wb_queue : report FIFO with address merge and host snoop         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ecc_wb_queue
  import ecc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              host_w_en_i,
  input  logic [ADDR_W-1:0] host_w_addr_i,
  output logic              head_valid_o,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              empty_o,
  output logic              drop_o
);

  localparam int          PW      = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW:0]       wr_q, rd_q;
  logic [PW-1:0]     wr_idx, rd_idx, hit_idx;
  logic              hit, full, accept;

  assign wr_idx  = wr_q[PW-1:0];
  assign rd_idx  = rd_q[PW-1:0];
  assign empty_o = (wr_q == rd_q);
  assign full    = (wr_q[PW] != rd_q[PW]) && (wr_idx == rd_idx);

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!hit && valid_q[k] && (addr_q[k] == push_addr_i)) begin
        hit     = 1'b1;
        hit_idx = PW'(k);
      end
    end
  end

  // A pop frees a slot in the same cycle, so a full queue still accepts.
  assign accept = push_i && !hit && (!full || pop_i);
  assign drop_o = push_i && !hit && full && !pop_i;

  assign head_addr_o  = addr_q[rd_idx];
  assign head_valid_o = valid_q[rd_idx] &&
                        !(host_w_en_i && (addr_q[rd_idx] == host_w_addr_i));
  assign head_data_o  = (push_i && hit && (hit_idx == rd_idx)) ? push_data_i
                                                               : data_q[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (host_w_en_i && (addr_q[k] == host_w_addr_i)) valid_q[k] <= 1'b0;
      end
      if (pop_i) begin
        valid_q[rd_idx] <= 1'b0;
        rd_q            <= rd_q + PTR_ONE;
      end
      if (accept) begin
        valid_q[wr_idx] <= 1'b1;
        wr_q            <= wr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && hit) begin
      data_q[hit_idx] <= push_data_i;
    end else if (accept) begin
      addr_q[wr_idx] <= push_addr_i;
      data_q[wr_idx] <= push_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/en64_RP2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | en64_RP2 : 64-bit SEC-DED check-bit encoder, one registered stage    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module en64_RP2 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] data_i,
  output logic [7:0]  chk_o
);

  // Data bit k sits at the k-th non-power-of-two codeword position (1..71).
  function automatic logic [63:0] cover_mask(input int j);
    logic [63:0] m;
    int          k;
    m = '0;
    k = 0;
    for (int pos = 1; pos < 72; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        m[k] = pos[j];
        k++;
      end
    end
    return m;
  endfunction

  logic [7:0] chk_d;
  logic [7:0] chk_q;

  always_comb begin
    chk_d = '0;
    for (int j = 0; j < 7; j++) begin
      chk_d[j] = ^(data_i & cover_mask(j));
    end
    chk_d[7] = ^{data_i, chk_d[6:0]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) chk_q <= '0;
    else        chk_q <= chk_d;
  end

  assign chk_o = chk_q;

endmodule
`default_nettype wire

// File: rtl/ecc_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ecc_writeback : queues corrected words and writes them back to SRAM  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ecc_writeback
  import ecc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CHK_W  = CHK_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              err_valid,
  input  logic [ADDR_W-1:0] err_addr,
  input  logic [DATA_W-1:0] err_data,
  input  logic              host_w_en,
  input  logic [ADDR_W-1:0] host_w_addr,
  output logic              wb_w_en,
  output logic [ADDR_W-1:0] wb_w_addr,
  output logic [DATA_W-1:0] wb_w_data,
  output logic [CHK_W-1:0]  wb_w_chk,
  output logic              busy,
  output logic [CNT_W-1:0]  wb_count,
  output logic [CNT_W-1:0]  drop_count
);

  wb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [CNT_W-1:0]  wb_count_q, drop_count_q;

  logic              q_empty, q_drop, q_push, q_pop, head_valid;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              host_hit_hold, host_discard, hold_merge, wb_fire;

  assign host_hit_hold = host_w_en && (state_q != IDLE) && (host_w_addr == hold_addr_q);
  assign host_discard  = err_valid && host_w_en && (err_addr == host_w_addr);
  assign hold_merge    = err_valid && !host_discard && (state_q != IDLE) &&
                         (err_addr == hold_addr_q);
  assign q_push        = err_valid && !host_discard && !hold_merge;
  assign q_pop         = (state_q == IDLE) && !q_empty;

  ecc_wb_queue #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (q_push),
    .push_addr_i  (err_addr),
    .push_data_i  (err_data),
    .pop_i        (q_pop),
    .host_w_en_i  (host_w_en),
    .host_w_addr_i(host_w_addr),
    .head_valid_o (head_valid),
    .head_addr_o  (head_addr),
    .head_data_o  (head_data),
    .empty_o      (q_empty),
    .drop_o       (q_drop)
  );

  en64_RP2 u_enc (
    .clk   (clk),
    .rst_n (rst_n),
    .data_i(hold_data_q),
    .chk_o (wb_w_chk)
  );

  // A merge into the held word re-runs ENC so the check bits follow the data.
  always_comb begin
    state_d     = state_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    wb_fire     = 1'b0;
    if (hold_merge) hold_data_d = err_data;
    case (state_q)
      IDLE: begin
        if (q_pop && head_valid) begin
          hold_addr_d = head_addr;
          hold_data_d = head_data;
          state_d     = ENC;
        end
      end
      ENC: begin
        if (host_hit_hold)    state_d = IDLE;
        else if (!hold_merge) state_d = WRITE;
      end
      WRITE: begin
        if (host_hit_hold)   state_d = IDLE;
        else if (hold_merge) state_d = ENC;
        else if (!host_w_en) begin
          wb_fire = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      wb_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      if (wb_fire) wb_count_q   <= sat_inc(wb_count_q);
      if (q_drop)  drop_count_q <= sat_inc(drop_count_q);
    end
  end

  assign wb_w_en    = wb_fire && rst_n;
  assign wb_w_addr  = hold_addr_q;
  assign wb_w_data  = hold_data_q;
  assign busy       = !q_empty || (state_q != IDLE);
  assign wb_count   = wb_count_q;
  assign drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: doc/ecc_writeback.md
# ecc_writeback

Write-side companion to the ECC read/compare path. It accepts corrected-word reports from the compare stage, consisting of an error flag, an address and the decoder's corrected 64-bit data. It queues those reports, regenerates check bits through the existing encoder, and writes the corrected data and check bits back into the data and check SRAMs when no host write is active. It sits between the compare stage's outputs and the shared SRAM write ports, in front of the host write mux.

## Interface
Parameters:
- ADDR_W, default 14: SRAM address width.
- DATA_W, default 64: payload width.
- CHK_W, default 8: check-bit width, matching the encoder output.
- DEPTH, default 4: report queue depth; must be a power of two, at least 2.

Ports:
- clk, input, 1: single clock.
- rst_n, input, 1: reset, synchronous and active-low.
- err_valid, input, 1: a corrected-word report is present this cycle.
- err_addr, input, ADDR_W: address of the corrupted word.
- err_data, input, DATA_W: corrected data from the decoder.
- host_w_en, input, 1: host write this cycle; always has priority.
- host_w_addr, input, ADDR_W: host write address.
- wb_w_en, output, 1: write-back strobe to both SRAMs.
- wb_w_addr, output, ADDR_W: write-back address.
- wb_w_data, output, DATA_W: corrected data.
- wb_w_chk, output, CHK_W: regenerated check bits.
- busy, output, 1: queue non-empty or FSM not IDLE.
- wb_count, output, 16: completed write-backs, saturating.
- drop_count, output, 16: reports lost to a full queue, saturating.

## Operation
Report queue:
- DEPTH entries; each holds a valid bit, address and data.
- Circular write and read pointers with wrap-around.
- Push on err_valid.

Push rules:
- If err_addr matches a valid queued entry, or the word held in ENC/WRITE, that entry's data is overwritten in place. No new entry is created.
- If the queue is full and there is no match, the report is dropped and drop_count increments.
- If err_valid and host_w_en occur in the same cycle with err_addr == host_w_addr, the report is discarded silently because host data is newer. It is not counted.

Host snoop:
- Every cycle with host_w_en=1, any valid queued entry whose address equals host_w_addr is invalidated.
- Invalid entries are skipped at pop and still free their slot.

FSM states:
- IDLE: if a valid head entry exists, pop it into the hold register and go to ENC. Invalid heads are popped and discarded with the FSM staying in IDLE.
- ENC: the hold data drives the encoder for one cycle; go to WRITE.
- WRITE:
  - If host_w_en=1 and host_w_addr == hold address, abort to IDLE with no write. The snoop takes priority over the stall.
  - Otherwise, if host_w_en=1, stay in WRITE with wb_w_en=0.
  - Otherwise assert wb_w_en for exactly one cycle, increment wb_count, and go to IDLE.
- A host write to the hold address during ENC also aborts to IDLE.

Arithmetic:
- Counters saturate at 16'hFFFF.
- Pointers are log2(DEPTH) bits plus one wrap bit for full/empty detection.

## Timing
Reset (rst_n=0 at a clk edge):
- Queue empty with all valid bits cleared.
- FSM in IDLE.
- wb_w_en=0; wb_w_addr, wb_w_data and wb_w_chk are 0.
- busy=0, wb_count=0, drop_count=0.

Reset asserted mid-operation discards the queue and the hold register. No write is issued on the reset cycle or afterwards.

Latency:
- err_valid sampled in cycle t with the queue empty and the FSM in IDLE.
- Pop in t+1, ENC in t+2, wb_w_en=1 in t+3 if host_w_en=0.
- Sustained throughput is one write-back per 3 cycles.

Outputs:
- wb_w_addr, wb_w_data and wb_w_chk are registered and stable throughout WRITE.
- wb_w_en is never high in a cycle with host_w_en=1.

Queue boundaries:
- A push and a pop in the same cycle while full is accepted; it is not a drop.
- A push to an empty queue is not visible to IDLE until the next cycle.

## Structure
- Shared package ecc_pkg: ADDR_W, DATA_W, CHK_W defaults; the FSM state enum (IDLE, ENC, WRITE); the counter width constant.
- Sub-module ecc_wb_queue: the queue with match-update, host snoop invalidation and the full/drop indication.
- The existing en64_RP2 encoder is instantiated for check generation. Its 1-cycle registered latency defines the ENC state.
- The top level contains the FSM, the hold register and the counters.

## Test plan
- Single report: err_addr=14'h0123, err_data=64'hDEADBEEF_00000001 at cycle 0 with host idle -> wb_w_en=1 in cycle 3 only, wb_w_addr=14'h0123, wb_w_chk equal to en64_RP2 of the data, wb_count=1.
- Host stall: same report with host_w_en=1 (addr 14'h0555) during cycles 3–5 -> wb_w_en=0 in cycles 3–5, =1 in cycle 6, never coincident with host_w_en.
- Overflow: DEPTH+2 distinct reports on consecutive cycles while the host holds host_w_en on an unrelated address -> drop_count=1 (the 1-cycle pop-to-ENC frees one slot), DEPTH+1 write-backs after release, in FIFO order.
- Merge: reports to 14'h0010 with data A, then 14'h0010 with data B while queued -> exactly one write, carrying B.
- Snoop and abort: report to 14'h0020, then host write to 14'h0020 in cycle 2 (ENC) -> no write-back, wb_count unchanged; repeat with a queued entry -> entry skipped.
- Reset mid-WRITE with 3 entries queued -> all outputs 0 the cycle after reset, no subsequent wb_w_en, busy=0.
